// File: rtl/wb_arbiter.sv
// Writeback arbiter between ALU and LSU with a registered register-file write port and busy scoreboard.
// Define WB_FAIR_EN for round-robin arbitration on contested cycles; otherwise LSU has fixed priority.
module wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    // Handshake: a request transfers in a cycle where valid && ready; ready is the
    // combinational grant, and a requester holds valid/rd/data stable until it sees ready.
    logic            grant_alu;
    logic            grant_lsu;
    logic            both_valid;

    logic            rf_we_q,    rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [31:0]     busy_q,     busy_d;

    assign both_valid = alu_valid && lsu_valid;

`ifdef WB_FAIR_EN
    // alu_next_q = 1 means the ALU wins the next contested cycle.
    logic alu_next_q, alu_next_d;

    always_comb begin
        alu_next_d = alu_next_q;
        if (both_valid) begin
            alu_next_d = ~alu_next_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_next_q <= 1'b0;
        end else begin
            alu_next_q <= alu_next_d;
        end
    end
`endif

    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (both_valid) begin
`ifdef WB_FAIR_EN
            if (alu_next_q) begin
                grant_alu = 1'b1;
            end else begin
                grant_lsu = 1'b1;
            end
`else
            grant_lsu = 1'b1;
`endif
        end else begin
            grant_alu = alu_valid;
            grant_lsu = lsu_valid;
        end
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;

    // Writes to x0 are accepted but never reach the register file.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = 5'd0;
        rf_wdata_d = '0;
        if (grant_alu) begin
            rf_we_d    = (alu_rd != 5'd0);
            rf_waddr_d = alu_rd;
            rf_wdata_d = alu_data;
        end else if (grant_lsu) begin
            rf_we_d    = (lsu_rd != 5'd0);
            rf_waddr_d = lsu_rd;
            rf_wdata_d = lsu_data;
        end
    end

    // Set is applied after clear so a same-edge issue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= '0;
            busy_q     <= 32'd0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign stall    = busy_q[rs1_addr] | busy_q[rs2_addr];
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of writeback and register file write data.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports alu_valid/alu_rd/alu_data, input, 1/5/XLEN, ALU writeback request, destination, data.
REQ-005 SHALL have port alu_ready, output, 1, ALU request accepted this cycle.
REQ-006 SHALL have ports lsu_valid/lsu_rd/lsu_data, input, 1/5/XLEN, load-unit writeback request, destination, data.
REQ-007 SHALL have port lsu_ready, output, 1, LSU request accepted this cycle.
REQ-008 SHALL have ports issue_valid/issue_rd, input, 1/5, instruction issued that will write issue_rd.
REQ-009 SHALL have ports rs1_addr/rs2_addr, input, 5/5, source registers of the instruction at issue.
REQ-010 SHALL have port stall, output, 1, a source register has a pending write.
REQ-011 SHALL have ports rf_we/rf_waddr/rf_wdata, output, 1/5/XLEN, register-file write port drive.

Function
REQ-012 SHALL accept at most one writeback per cycle; acceptance = valid && ready on that requester, ready combinational from current valids and arbitration state.
REQ-013 SHALL assert ready on a requester only when that requester is granted; requesters hold valid/rd/data stable until ready.
REQ-014 SHALL with only one requester valid grant it; with none valid, both ready low.
REQ-015 SHALL register the granted request: grant in cycle N -> rf_we=1, rf_waddr=rd, rf_wdata=data in cycle N+1; otherwise rf_we=0 in N+1.
REQ-016 SHALL accept requests with rd=0 (ready asserted) but drive rf_we=0 for them, no scoreboard effect.
REQ-017 SHALL keep a 32-bit busy scoreboard; busy[0] is constant 0.
REQ-018 SHALL set busy[issue_rd] at the clock edge ending a cycle with issue_valid=1 and issue_rd!=0.
REQ-019 SHALL clear busy[rf_waddr] at the clock edge ending a cycle with rf_we=1 (same edge the register file commits), so a reader in the following cycle sees the new value.
REQ-020 SHALL give set priority when set and clear target the same register on the same edge.
REQ-021 SHALL drive stall = busy[rs1_addr] | busy[rs2_addr], combinational; address 0 never stalls.
REQ-022 SHALL not gate issue_valid with stall; the issuer is responsible for not issuing while stall=1.

Reset
REQ-023 SHALL on rst=1 at a clock edge clear all busy bits, rf_we=0, rf_waddr=0, rf_wdata=0, arbitration pointer to "LSU next".
REQ-024 SHALL discard a request granted in the cycle rst is high (no rf_we in the following cycle); alu_ready/lsu_ready remain combinational during reset.
REQ-025 SHALL drive stall=0 in the first cycle after reset.

Configuration
REQ-026 SHALL, with WB_FAIR_EN defined, arbitrate round-robin: when both valid, grant the requester not granted at the last contested grant; pointer updates only on contested grants.
REQ-027 SHALL, with WB_FAIR_EN undefined, use fixed priority: LSU always wins when both valid; no pointer state.

Verification
REQ-028 SHALL cover: reset, alu_valid=1 rd=5 data=0xDEADBEEF -> alu_ready=1 same cycle, next cycle rf_we=1 rf_waddr=5 rf_wdata=0xDEADBEEF.
REQ-029 SHALL cover: both valid 3 cycles (alu rd=1, lsu rd=2), WB_FAIR_EN defined -> grants LSU, ALU, LSU; undefined -> LSU every cycle, alu_ready=0.
REQ-030 SHALL cover: issue_valid rd=7, then rs1_addr=7 -> stall=1 until the cycle after rf_we=1 rf_waddr=7, then stall=0.
REQ-031 SHALL cover: issue rd=9 in the same cycle rf_we=1 rf_waddr=9 -> busy[9] stays 1, stall=1 with rs2_addr=9.
REQ-032 SHALL cover: lsu_valid rd=0 data=0x1234 -> lsu_ready=1, next cycle rf_we=0; rs1_addr=0 -> stall=0.
REQ-033 SHALL cover: rst asserted in a grant cycle with busy[3]=1 -> next cycle rf_we=0, stall=0 for rs1_addr=3.
